vga_timing_gen: RTL and testbench

Parametrised raster timing generator that replaces the fixed 640x480 controller in the video path. It advances horizontal and vertical position counters once per `pixel_strobe` and emits registered sync, active, blanking and position outputs. It also emits single-cycle line, frame and animation event strobes and an optional frame counter for the game logic and sprite renderers. Any mode is selected by parameters, with sync polarity programmable per axis and a synchronous frame restart.

---
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters advanced by pixel_strobe; sync/active/position/event outputs. Optional VGA_TIMING_FRAME_CNT_EN.
// Latency: outputs are registered on the edge that advances the counters, 1 clk after the strobe.
// Backpressure: none; pixel_strobe low holds the counters and levels, and the pulses drop to 0.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixel_strobe,
    input  logic               restart,
    output logic               horizontal_sync,
    output logic               vertical_sync,
    output logic               active,
    output logic               blanking,
    output logic [X_W-1:0]     X_output,
    output logic [Y_W-1:0]     Y_output,
    output logic               line_start,
    output logic               frame_start,
    output logic               animate,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] X_MAX    = X_W'(H_ACTIVE - 1);
    localparam logic [X_W-1:0] HS_BEGIN = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] Y_MAX    = Y_W'(V_ACTIVE - 1);
    localparam logic [Y_W-1:0] VS_BEGIN = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic           HS_ON    = (H_SYNC_POL != 0);
    localparam logic           VS_ON    = (V_SYNC_POL != 0);

    logic [X_W-1:0] h, h_nx;
    logic [Y_W-1:0] v, v_nx;
    logic           step;
    logic           enter_line;
    logic           enter_frame;

    // Next position; restart parks the counters and swallows any coincident strobe.
    always_comb begin
        h_nx = h;
        v_nx = v;
        step = 1'b0;
        if (restart) begin
            h_nx = H_LAST;
            v_nx = V_LAST;
        end else if (pixel_strobe) begin
            step = 1'b1;
            if (h == H_LAST) begin
                h_nx = '0;
                v_nx = (v == V_LAST) ? '0 : v + Y_W'(1);
            end else begin
                h_nx = h + X_W'(1);
            end
        end
    end

    assign enter_line  = step && (h_nx == '0);
    assign enter_frame = enter_line && (v_nx == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h               <= H_LAST;
            v               <= V_LAST;
            horizontal_sync <= ~HS_ON;
            vertical_sync   <= ~VS_ON;
            active          <= 1'b0;
            blanking        <= 1'b1;
            X_output        <= X_MAX;
            Y_output        <= Y_MAX;
            line_start      <= 1'b0;
            frame_start     <= 1'b0;
            animate         <= 1'b0;
        end else begin
            h           <= h_nx;
            v           <= v_nx;
            line_start  <= enter_line;
            frame_start <= enter_frame;
            animate     <= enter_line && (v_nx == V_ACT);
            if (restart) begin
                horizontal_sync <= ~HS_ON;
                vertical_sync   <= ~VS_ON;
                active          <= 1'b0;
                blanking        <= 1'b1;
                X_output        <= X_MAX;
                Y_output        <= Y_MAX;
            end else if (pixel_strobe) begin
                horizontal_sync <= (h_nx >= HS_BEGIN && h_nx < HS_END) ? HS_ON : ~HS_ON;
                vertical_sync   <= (v_nx >= VS_BEGIN && v_nx < VS_END) ? VS_ON : ~VS_ON;
                active          <= (h_nx < H_ACT) && (v_nx < V_ACT);
                blanking        <= !((h_nx < H_ACT) && (v_nx < V_ACT));
                X_output        <= (h_nx > X_MAX) ? X_MAX : h_nx;
                Y_output        <= (v_nx > Y_MAX) ? Y_MAX : v_nx;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
        end else if (enter_frame) begin
            frame_count <= frame_count + FRAME_W'(1);
        end
    end
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen in a small mode (H 8/2/2/2, V 4/1/1/1, active-low syncs).
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pixel_strobe = 1'b0;
    logic       restart = 1'b0;
    logic       horizontal_sync, vertical_sync, active, blanking;
    logic [9:0] X_output, Y_output;
    logic       line_start, frame_start, animate;
    logic [7:0] frame_count;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0),
        .X_W(10), .Y_W(10), .FRAME_W(8)
    ) dut (
        .clk(clk), .reset(reset), .pixel_strobe(pixel_strobe), .restart(restart),
        .horizontal_sync(horizontal_sync), .vertical_sync(vertical_sync),
        .active(active), .blanking(blanking), .X_output(X_output), .Y_output(Y_output),
        .line_start(line_start), .frame_start(frame_start), .animate(animate),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hs, vs, act, blk;
        logic [9:0] x, y;
        logic       ls, fs, an;
        logic [7:0] fc;
    } obs_t;

    int    checks = 0;
    int    failures = 0;
    obs_t  exp_q[$];
    string name_q[$];
    int    fs_cyc[$];
    int    an_cnt = 0;
    int    cyc = 0;

    // Reference position and frame count, advanced once per driven cycle.
    int         mh, mv;
    logic [7:0] mfc;
    obs_t       prev;

    function automatic obs_t rst_vals(input logic [7:0] fc);
        obs_t e;
        e = '0;
        e.hs = 1'b1; e.vs = 1'b1; e.act = 1'b0; e.blk = 1'b1;
        e.x = 10'd7; e.y = 10'd3; e.fc = fc;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t g;
        g.hs = horizontal_sync; g.vs = vertical_sync; g.act = active; g.blk = blanking;
        g.x = X_output; g.y = Y_output;
        g.ls = line_start; g.fs = frame_start; g.an = animate; g.fc = frame_count;
        return g;
    endfunction

    task automatic check(input string nm, input obs_t e);
        obs_t g;
        g = sample();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got hs=%b vs=%b act=%b blk=%b x=%0d y=%0d ls=%b fs=%b an=%b fc=%0d required hs=%b vs=%b act=%b blk=%b x=%0d y=%0d ls=%b fs=%b an=%b fc=%0d",
                     nm, g.hs, g.vs, g.act, g.blk, g.x, g.y, g.ls, g.fs, g.an, g.fc,
                     e.hs, e.vs, e.act, e.blk, e.x, e.y, e.ls, e.fs, e.an, e.fc);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got %0d required %0d", nm, got, req);
        end
    endtask

    task automatic model_reset();
        mh = 13; mv = 6; mfc = 8'd0;
        prev = rst_vals(8'd0);
    endtask

    task automatic model_step(input logic s, input logic r, output obs_t e);
        if (r) begin
            mh = 13; mv = 6;
            e = rst_vals(mfc);
        end else if (s) begin
            if (mh == 13) begin
                mh = 0;
                mv = (mv == 6) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            e.hs  = !(mh == 10 || mh == 11);
            e.vs  = (mv != 5);
            e.act = (mh < 8) && (mv < 4);
            e.blk = !e.act;
            e.x   = (mh > 7) ? 10'd7 : 10'(mh);
            e.y   = (mv > 3) ? 10'd3 : 10'(mv);
            e.ls  = (mh == 0);
            e.fs  = e.ls && (mv == 0);
            e.an  = e.ls && (mv == 4);
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (e.fs) mfc = mfc + 8'd1;
`endif
            e.fc = mfc;
        end else begin
            e = prev;
            e.ls = 1'b0; e.fs = 1'b0; e.an = 1'b0;
        end
        prev = e;
    endtask

    task automatic drive(input logic s, input logic r, input string nm);
        obs_t e;
        @(negedge clk);
        pixel_strobe = s;
        restart = r;
        model_step(s, r, e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compares each queued expectation against the outputs after the edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (frame_start) fs_cyc.push_back(cyc);
        if (animate) an_cnt++;
        if (exp_q.size() > 0) begin
            check(name_q.pop_front(), exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2 reset = 1'b1;
        #2 check("reset_async_assert", rst_vals(8'd0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_hold", rst_vals(8'd0));

        drive(1'b1, 1'b0, "first_strobe");
        drive(1'b0, 1'b0, "idle_hold_a");
        drive(1'b0, 1'b0, "idle_hold_b");

        // Two frames back-to-back starting from (0,0).
        fs_cyc.delete();
        an_cnt = 0;
        for (int i = 0; i < 196; i++) drive(1'b1, 1'b0, "b2b_frames");
        drive(1'b0, 1'b0, "b2b_tail");
        repeat (2) @(posedge clk);
        #2;
        check_int("b2b_frame_starts", fs_cyc.size(), 2);
        if (fs_cyc.size() == 2) check_int("b2b_frame_period", fs_cyc[1] - fs_cyc[0], 98);
        check_int("b2b_animate_count", an_cnt, 2);

        // Strobe every third clk.
        fs_cyc.delete();
        an_cnt = 0;
        for (int i = 0; i < 196; i++) begin
            drive(1'b1, 1'b0, "slow_strobe");
            drive(1'b0, 1'b0, "slow_gap1");
            drive(1'b0, 1'b0, "slow_gap2");
        end
        repeat (2) @(posedge clk);
        #2;
        check_int("slow_frame_starts", fs_cyc.size(), 2);
        if (fs_cyc.size() == 2) check_int("slow_frame_period", fs_cyc[1] - fs_cyc[0], 294);
        check_int("slow_animate_count", an_cnt, 2);

        // Restart with a coincident strobe at h=5, v=2.
        for (int i = 0; i < 33; i++) drive(1'b1, 1'b0, "to_restart_point");
        check_int("restart_point_h", mh, 5);
        check_int("restart_point_v", mv, 2);
        drive(1'b1, 1'b1, "restart_with_strobe");
        drive(1'b1, 1'b0, "after_restart");
        drive(1'b1, 1'b0, "after_restart_2");

        // Asynchronous reset between edges, mid-frame.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, "pre_async");
        drive(1'b0, 1'b0, "pre_async_idle");
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check("async_reset_mid", rst_vals(8'd0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, "post_reset_strobe");
        drive(1'b1, 1'b0, "post_reset_strobe_2");
        drive(1'b0, 1'b0, "final_idle");

        repeat (3) @(posedge clk);
        #2;
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
